uart_rx_frame: RTL



---
 rtl/uart_rx_frame.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame
// Brief    : Parametrised UART receiver with 2-flop synchroniser, 3-sample
//            majority voting, parity/framing/overrun/break status, a
//            valid/ready holding register and inter-frame idle detection.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame #(
    parameter int CLK_FREQ_HZ = 80_000_000,
    parameter int BAUDRATE    = 187_500,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int IDLE_BITS   = 39
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 frame_end,
    output logic                 busy
);

    localparam int C_CPB  = CLK_FREQ_HZ / BAUDRATE;
    localparam int C_HALF = C_CPB / 2;
    localparam int C_CW   = ($clog2(C_CPB) > 16) ? $clog2(C_CPB) : 16;

    localparam logic [C_CW-1:0] C_S0        = C_CW'(C_HALF - 1);
    localparam logic [C_CW-1:0] C_S1        = C_CW'(C_HALF);
    localparam logic [C_CW-1:0] C_S2        = C_CW'(C_HALF + 1);
    localparam logic [C_CW-1:0] C_LAST      = C_CW'(C_CPB - 1);
    localparam logic [15:0]     C_IDLE_LAST = 16'(IDLE_BITS - 1);
    localparam logic [3:0]      C_BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]      C_STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    logic                   r_sync1;
    logic                   r_rxs;
    logic                   r_rxs_prev;
    logic [C_CW-1:0]        r_cnt;
    logic [3:0]             r_bit;
    logic                   r_s0;
    logic                   r_s1;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_perr_acc;
    logic                   r_ferr_acc;
    logic                   r_idle_armed;
    logic [C_CW-1:0]        r_idle_cyc;
    logic [15:0]            r_idle_bits;

    logic w_start_edge;
    logic w_vote;
    logic w_ferr_final;

    assign w_start_edge = r_rxs_prev & ~r_rxs;
    assign w_vote       = (r_s0 & r_s1) | (r_s0 & r_rxs) | (r_s1 & r_rxs);
    assign w_ferr_final = r_ferr_acc | ~w_vote;

    // Bring the asynchronous line into the clock domain and keep one
    // delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_rxs      <= 1'b1;
            r_rxs_prev <= 1'b1;
        end else begin
            r_sync1    <= rx;
            r_rxs      <= r_sync1;
            r_rxs_prev <= r_rxs;
        end
    end

    // Receive FSM, bit timing, holding register, handshake and idle timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_s0         <= 1'b1;
            r_s1         <= 1'b1;
            r_shift      <= '0;
            r_perr_acc   <= 1'b0;
            r_ferr_acc   <= 1'b0;
            r_idle_armed <= 1'b0;
            r_idle_cyc   <= '0;
            r_idle_bits  <= '0;
            data         <= '0;
            data_valid   <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            break_det    <= 1'b0;
            overrun      <= 1'b0;
            frame_end    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            frame_end <= 1'b0;

            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            // The two early samples are latched; the third is taken live
            // from the synchroniser at the decision count.
            if (r_state != S_IDLE) begin
                if (r_cnt == C_S0) r_s0 <= r_rxs;
                if (r_cnt == C_S1) r_s1 <= r_rxs;
                r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_state      <= S_START;
                        r_cnt        <= '0;
                        r_bit        <= '0;
                        r_perr_acc   <= 1'b0;
                        r_ferr_acc   <= 1'b0;
                        r_idle_armed <= 1'b0;
                        busy         <= 1'b1;
                    end else if (r_idle_armed) begin
                        if (r_idle_cyc == C_LAST) begin
                            r_idle_cyc <= '0;
                            if (r_idle_bits == C_IDLE_LAST) begin
                                frame_end    <= 1'b1;
                                r_idle_armed <= 1'b0;
                            end else begin
                                r_idle_bits <= r_idle_bits + 1'b1;
                            end
                        end else begin
                            r_idle_cyc <= r_idle_cyc + 1'b1;
                        end
                    end
                end

                S_START: begin
                    if (r_cnt == C_S2 && w_vote) begin
                        // Glitch shorter than half a bit: drop silently.
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                    end else if (r_cnt == C_LAST) begin
                        r_state <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (r_cnt == C_S2) begin
                        r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                    end
                    if (r_cnt == C_LAST) begin
                        if (r_bit == C_BIT_LAST) begin
                            r_bit   <= '0;
                            r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end
                end

                S_PARITY: begin
                    if (r_cnt == C_S2) begin
                        r_perr_acc <= (PARITY == 1) ? (w_vote != ^r_shift)
                                                    : (w_vote == ^r_shift);
                    end
                    if (r_cnt == C_LAST) begin
                        r_state <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (r_cnt == C_S2) begin
                        if (r_bit == C_STOP_LAST) begin
                            // Leave mid-stop-bit so the next start edge
                            // is never missed on back-to-back traffic.
                            r_state      <= S_IDLE;
                            r_cnt        <= '0;
                            r_bit        <= '0;
                            busy         <= 1'b0;
                            data         <= r_shift;
                            parity_err   <= r_perr_acc;
                            frame_err    <= w_ferr_final;
                            break_det    <= w_ferr_final & ~(|r_shift);
                            overrun      <= data_valid & ~data_ready;
                            data_valid   <= 1'b1;
                            r_idle_armed <= 1'b1;
                            r_idle_cyc   <= '0;
                            r_idle_bits  <= '0;
                        end else begin
                            r_ferr_acc <= w_ferr_final;
                        end
                    end
                    if (r_cnt == C_LAST) begin
                        r_bit <= r_bit + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
